max_frame_ctrl: RTL and testbench
=================================

// Module: max_frame_ctrl
// PURPOSE
//  Sequencer for the running-maximum datapath (max register + X>max compare).
//  Takes a frame length, clears the datapath and feeds it exactly that many samples.
//  Samples arrive through a valid/ready stream; the frame maximum leaves through a
//  valid/ready result port.
//  Sits between the sample source and the max datapath, and owns all clear/enable timing.
// PARAMETERS
//  W      32  sample / maximum width (unsigned)
//  LEN_W  7   frame-length counter width; max frame = 2**LEN_W-1 samples
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst        in   1      asynchronous reset, active-low
//  start      in   1      pulse: begin a frame (honoured in IDLE only)
//  abort      in   1      cancel current frame; return to IDLE, no result
//  cfg_len    in   LEN_W  frame length in samples, sampled when start is accepted
//  in_valid   in   1      sample valid
//  in_data    in   W      sample value
//  in_ready   out  1      controller accepts sample this cycle
//  dp_clr     out  1      datapath clear (max := 0)
//  dp_en      out  1      datapath update enable
//  dp_x       out  W      sample forwarded to the datapath
//  dp_max     in   W      datapath max register (valid 1 cycle after dp_en)
//  res_valid  out  1      result available
//  res_ready  in   1      result consumer ready
//  res_max    out  W      frame maximum
//  res_cnt    out  LEN_W  samples consumed in the frame
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0; cnt, len, res_max, res_cnt = 0.
//  FSM states: IDLE, CLEAR, RUN, SETTLE, DONE.
//  IDLE: start=1 latches len:=cfg_len.
//   - cfg_len!=0 -> CLEAR.
//   - cfg_len==0 -> DONE with res_max=0, res_cnt=0; dp not touched.
//  CLEAR: dp_clr=1 for exactly 1 cycle; cnt:=0 -> RUN.
//  RUN: in_ready=1; dp_x=in_data combinationally.
//   - Each in_valid&in_ready cycle: dp_en=1, cnt:=cnt+1.
//   - Accept with cnt==len-1 -> SETTLE; in_ready drops the next cycle.
//  SETTLE: 1 cycle, waiting for the dp_max register update; res_max:=dp_max,
//   res_cnt:=len -> DONE.
//  DONE: res_valid=1; res_max/res_cnt held stable until res_valid&res_ready.
//   - Handshake -> IDLE.
//   - res_valid is never dropped without the handshake (except abort/reset).
//  Latency: last sample accepted at cycle t -> res_valid=1 at t+2.
//  in_ready=0 and dp_en=0 outside RUN; dp_clr and dp_en are never both 1.
//  start outside IDLE: ignored, no effect on len or cnt.
//  abort: priority over all other inputs in every state -> IDLE next cycle.
//   - Clears res_valid; does not pulse dp_clr.
//   - abort and start together in IDLE: stay IDLE.
//  cnt never wraps: the frame ends at len <= 2**LEN_W-1.
//  Unsigned compare in the datapath; controller does no arithmetic on data.
//  Reset mid-frame: immediate IDLE; the partial frame is discarded.
// TESTING
//  1. len=100, samples 0..99 ascending, in_valid constant -> res_max=99,
//     res_cnt=100, res_valid 2 cycles after the 100th accept.
//  2. len=5, samples {7,300,2,300,1} with in_valid gaps -> res_max=300, res_cnt=5;
//     dp_en only on accepted beats.
//  3. len=0, start -> DONE next cycle, res_max=0, res_cnt=0; no dp_clr/dp_en.
//  4. res_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0;
//     start ignored; IDLE after res_ready=1.
//  5. abort after 3 of 8 samples -> IDLE next cycle, res_valid never 1;
//     new start with len=2, samples {4,9} -> res_max=9 (dp_clr seen first).
//  6. rst=0 asserted mid-RUN, off-clock-edge -> all outputs 0 immediately;
//     after release a full frame (len=127, max 0xFFFFFFFF) completes correctly.

Source files
------------

// File: rtl/max_frame_ctrl_if.sv
// Stream, datapath and result signals of the running-maximum frame controller.
// The slave modport is the controller's view; master is the surrounding system's.
interface max_frame_ctrl_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned LEN_W = 7
);
   logic             start;
   logic             abort;
   logic [LEN_W-1:0] cfg_len;
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             in_ready;
   logic             dp_clr;
   logic             dp_en;
   logic [W-1:0]     dp_x;
   logic [W-1:0]     dp_max;
   logic             res_valid;
   logic             res_ready;
   logic [W-1:0]     res_max;
   logic [LEN_W-1:0] res_cnt;
   logic             busy;

   modport slave (
      input  start, abort, cfg_len, in_valid, in_data, dp_max, res_ready,
      output in_ready, dp_clr, dp_en, dp_x, res_valid, res_max, res_cnt, busy
   );

   modport master (
      output start, abort, cfg_len, in_valid, in_data, dp_max, res_ready,
      input  in_ready, dp_clr, dp_en, dp_x, res_valid, res_max, res_cnt, busy
   );
endinterface

// File: rtl/max_frame_ctrl.sv
// Frame sequencer for the running-maximum datapath: clears it, feeds cfg_len
// samples from the input stream, then presents the captured maximum.
module max_frame_ctrl #(
   parameter int unsigned W     = 32,
   parameter int unsigned LEN_W = 7
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   max_frame_ctrl_if.slave io_bus
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_len;
   logic [W-1:0]     r_res_max;
   logic [LEN_W-1:0] r_res_cnt;

   logic             w_in_ready;
   logic             w_dp_clr;
   logic             w_dp_en;
   logic [W-1:0]     w_dp_x;
   logic             w_res_valid;
   logic             w_accept;
   logic             w_last;

   assign w_last = (r_cnt == (r_len - LEN_W'(1)));

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_dp_clr    = 1'b0;
      w_dp_en     = 1'b0;
      w_dp_x      = '0;
      w_res_valid = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.start)
               w_next = (io_bus.cfg_len != '0) ? S_CLEAR : S_DONE;
         end
         S_CLEAR: begin
            w_dp_clr = 1'b1;
            w_next   = S_RUN;
         end
         S_RUN: begin
            // abort wins over a beat offered in the same cycle
            w_in_ready = !io_bus.abort;
            w_dp_x     = io_bus.in_data;
            w_accept   = io_bus.in_valid && !io_bus.abort;
            w_dp_en    = w_accept;
            if (w_accept && w_last)
               w_next = S_SETTLE;
         end
         S_SETTLE: w_next = S_DONE;
         S_DONE: begin
            w_res_valid = 1'b1;
            if (io_bus.res_ready)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (io_bus.abort)
         w_next = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_len     <= '0;
         r_res_max <= '0;
         r_res_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && io_bus.start && !io_bus.abort) begin
            r_len <= io_bus.cfg_len;
            if (io_bus.cfg_len == '0) begin
               r_res_max <= '0;
               r_res_cnt <= '0;
            end
         end
         if (w_dp_clr)
            r_cnt <= '0;
         else if (w_accept)
            r_cnt <= r_cnt + LEN_W'(1);
         // dp_max reflects the final beat one cycle after its dp_en
         if (r_state == S_SETTLE && !io_bus.abort) begin
            r_res_max <= io_bus.dp_max;
            r_res_cnt <= r_len;
         end
      end
   end

   assign io_bus.in_ready  = w_in_ready;
   assign io_bus.dp_clr    = w_dp_clr;
   assign io_bus.dp_en     = w_dp_en;
   assign io_bus.dp_x      = w_dp_x;
   assign io_bus.res_valid = w_res_valid;
   assign io_bus.res_max   = r_res_max;
   assign io_bus.res_cnt   = r_res_cnt;
   assign io_bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_max_frame_ctrl.sv
// Directed and randomized frames against a max-of-samples reference model,
// with a behavioural max-register datapath closing the loop.
module tb_max_frame_ctrl;
   localparam int unsigned W  = 32;
   localparam int unsigned LW = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   max_frame_ctrl_if #(.W(W), .LEN_W(LW)) bus ();

   max_frame_ctrl #(.W(W), .LEN_W(LW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus.slave)
   );

   // Max register datapath; deliberately not reset so only dp_clr zeroes it
   logic [W-1:0] dp_reg = 32'h5A5A_5A5A;
   assign bus.dp_max = dp_reg;
   always @(posedge clk) begin
      if (bus.dp_clr)                        dp_reg <= '0;
      else if (bus.dp_en && bus.dp_x > dp_reg) dp_reg <= bus.dp_x;
   end

   int n_clr = 0, n_en = 0, n_both = 0, n_bad_en = 0, n_rv = 0;
   always @(posedge clk) begin
      if (bus.dp_clr) n_clr <= n_clr + 1;
      if (bus.dp_en) n_en <= n_en + 1;
      if (bus.dp_clr && bus.dp_en) n_both <= n_both + 1;
      if (bus.dp_en && !(bus.in_valid && bus.in_ready)) n_bad_en <= n_bad_en + 1;
      if (bus.res_valid) n_rv <= n_rv + 1;
   end

   logic [W-1:0] smp[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  64'(bus.busy), 64'd0);
      chk({tag, "_rdy"},   64'(bus.in_ready), 64'd0);
      chk({tag, "_clr"},   64'(bus.dp_clr), 64'd0);
      chk({tag, "_en"},    64'(bus.dp_en), 64'd0);
      chk({tag, "_dpx"},   64'(bus.dp_x), 64'd0);
      chk({tag, "_rv"},    64'(bus.res_valid), 64'd0);
      chk({tag, "_rmax"},  64'(bus.res_max), 64'd0);
      chk({tag, "_rcnt"},  64'(bus.res_cnt), 64'd0);
   endtask

   // Runs one frame over smp[]; gap_pct = chance of an idle beat, hold = DONE cycles before res_ready
   task automatic run_frame(input string tag, input int len, input int gap_pct, input int hold);
      logic [W-1:0] emax;
      int clr0, en0, idx, guard;
      logic [W-1:0] hmax;
      logic [LW-1:0] hcnt;
      emax = '0;
      foreach (smp[i]) if (smp[i] > emax) emax = smp[i];
      @(negedge clk);
      bus.start = 1'b1; bus.cfg_len = LW'(len);
      clr0 = n_clr; en0 = n_en;
      @(negedge clk);
      bus.start = 1'b0;
      if (len == 0) begin
         chk({tag, "_len0_rv"}, 64'(bus.res_valid), 64'd1);
      end else begin
         chk({tag, "_clr_first"}, 64'(bus.dp_clr), 64'd1);
         chk({tag, "_no_en_before_clr"}, 64'(n_en), 64'(en0));
         @(negedge clk);
         idx = 0; guard = 0;
         while (idx < len && guard < 4000) begin
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            bus.in_data  = bus.in_valid ? smp[idx] : $urandom;
            #1;
            if (bus.in_valid) chk({tag, "_dpx"}, 64'(bus.dp_x), 64'(smp[idx]));
            chk({tag, "_dpen_beat"}, 64'(bus.dp_en), 64'(bus.in_valid));
            if (bus.in_valid && bus.in_ready) idx++;
            guard++;
            @(negedge clk);
         end
         chk({tag, "_accepted"}, 64'(idx), 64'(len));
         bus.in_valid = 1'b0;
         #1;
         chk({tag, "_rdy_drop"}, 64'(bus.in_ready), 64'd0);
         chk({tag, "_rv_t1"}, 64'(bus.res_valid), 64'd0);
         @(negedge clk);
         chk({tag, "_rv_t2"}, 64'(bus.res_valid), 64'd1);
      end
      chk({tag, "_res_max"}, 64'(bus.res_max), 64'(emax));
      chk({tag, "_res_cnt"}, 64'(bus.res_cnt), 64'(len));
      chk({tag, "_n_en"}, 64'(n_en - en0), 64'(len));
      chk({tag, "_n_clr"}, 64'(n_clr - clr0), 64'((len == 0) ? 0 : 1));
      hmax = bus.res_max; hcnt = bus.res_cnt;
      for (int h = 0; h < hold; h++) begin
         bus.start = 1'b1; bus.cfg_len = LW'($urandom);
         @(negedge clk);
         chk({tag, "_hold_rv"}, 64'(bus.res_valid), 64'd1);
         chk({tag, "_hold_max"}, 64'(bus.res_max), 64'(hmax));
         chk({tag, "_hold_cnt"}, 64'(bus.res_cnt), 64'(hcnt));
         chk({tag, "_hold_rdy"}, 64'(bus.in_ready), 64'd0);
      end
      bus.start = 1'b0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_idle_rv"}, 64'(bus.res_valid), 64'd0);
   endtask

   initial begin
      int acc, guard, rv0, len;
      bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_len = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;

      #2 chk_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;

      // ascending 0..99, no gaps
      smp.delete(); for (int i = 0; i < 100; i++) smp.push_back(W'(i));
      run_frame("asc100", 100, 0, 0);

      smp = '{32'd7, 32'd300, 32'd2, 32'd300, 32'd1};
      run_frame("gaps5", 5, 40, 0);

      smp.delete();
      run_frame("len0", 0, 0, 0);

      smp = '{32'd11, 32'd5, 32'd99, 32'd3};
      run_frame("hold10", 4, 20, 10);

      // abort after 3 of 8 accepted samples
      @(negedge clk); bus.start = 1'b1; bus.cfg_len = LW'(8);
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      rv0 = n_rv; acc = 0; guard = 0;
      while (acc < 3 && guard < 100) begin
         bus.in_valid = 1'b1; bus.in_data = W'(1000 + acc);
         #1;
         if (bus.in_ready) acc++;
         guard++;
         @(negedge clk);
      end
      chk("abort_acc3", 64'(acc), 64'd3);
      bus.abort = 1'b1; bus.in_data = W'(5000);
      #1 chk("abort_no_en", 64'(bus.dp_en), 64'd0);
      @(negedge clk);
      bus.abort = 1'b0; bus.in_valid = 1'b0;
      chk("abort_idle", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("abort_no_rv", 64'(n_rv), 64'(rv0));
      bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_len = LW'(5);
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("abort_start_idle", 64'(bus.busy), 64'd0);
      smp = '{32'd4, 32'd9};
      run_frame("after_abort", 2, 0, 0);

      // async reset mid-RUN
      @(negedge clk); bus.start = 1'b1; bus.cfg_len = LW'(20);
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 32'hCAFE_F00D;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midreset");
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      smp.delete();
      for (int i = 0; i < 127; i++) smp.push_back(W'($urandom) & 32'h7FFF_FFFF);
      smp[$urandom_range(126)] = 32'hFFFF_FFFF;
      run_frame("full127", 127, 10, 1);

      for (int f = 0; f < 6; f++) begin
         len = $urandom_range(30, 1);
         smp.delete();
         for (int i = 0; i < len; i++) smp.push_back(W'($urandom));
         run_frame($sformatf("rnd%0d", f), len, $urandom_range(60), $urandom_range(3));
      end

      chk("never_clr_and_en", 64'(n_both), 64'd0);
      chk("en_only_on_accept", 64'(n_bad_en), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
